// File: rtl/product_accumulator.sv
// Streaming accumulate stage behind the 8x8 multiplier: sums N_TERMS
// products per result and hands the sum off on a valid/ready port.
module product_accumulator #(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);

    localparam logic [0:0] S_ACCUM = 1'b0;
    localparam logic [0:0] S_DONE  = 1'b1;
    localparam logic [7:0] LAST    = 8'(N_TERMS - 1);

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;
    logic             accept;

    assign in_ready  = (state_q == S_ACCUM) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;

    assign accept = in_valid && (state_q == S_ACCUM);
    // Extra top bit of the sum is the carry-out of the ACC_W-bit add
    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, z};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_ACCUM: begin
                if (accept) begin
                    acc_d = sum[ACC_W-1:0];
                    ovf_d = ovf_q | sum[ACC_W];
                    if (cnt_q == LAST) begin
                        cnt_d   = 8'd0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_ACCUM;
                end
            end
            default: state_d = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ACCUM;
            acc_q   <= '0;
            cnt_q   <= 8'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulate stage placed directly downstream of the 8x8 combinational `multiplier`. It consumes the 16-bit product `z` one term per accepted handshake and sums `N_TERMS` consecutive products into an `ACC_W`-bit dot-product result. It presents the result on a valid/ready output and flags arithmetic overflow. This turns the multiplier into a streaming multiply-accumulate datapath.

## Interface

- `N_TERMS`, default 4: products per result; legal range 1..255.
- `ACC_W`, default 24: accumulator and result width; legal range 16..32.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  upstream product `z` is valid this cycle.
- `in_ready`  output  1  block accepts a product this cycle.
- `z`  input  16  unsigned product from `multiplier`.
- `out_valid`  output  1  `acc_out` holds a completed result.
- `out_ready`  input  1  downstream accepts the result.
- `acc_out`  output  ACC_W  unsigned sum of `N_TERMS` products, modulo 2^ACC_W.
- `overflow`  output  1  the sum exceeded 2^ACC_W-1; valid while `out_valid` is high.

## Operation

- Two states: ACCUM and DONE.
- `in_ready` = (state == ACCUM) && !rst. `out_valid` = (state == DONE).
- Accept = `in_valid` && `in_ready`. Each accept performs:
  - acc <= acc + zero-extend(z);
  - count <= count + 1;
  - overflow <= overflow | carry-out of the ACC_W-bit add.
- On the accept where count == N_TERMS-1:
  - store the final sum in acc;
  - reset count to 0;
  - move to DONE.
- DONE:
  - `acc_out` and `overflow` hold steady.
  - `in_ready` = 0; upstream stalls.
  - On `out_valid` && `out_ready`: acc <= 0, overflow <= 0, move to ACCUM.
- A cycle with `in_valid` = 0 in ACCUM changes nothing (bubble).
- `acc_out` is driven from the acc register at all times. It is meaningful only while `out_valid` = 1.
- `N_TERMS` = 1: every accept goes straight to DONE, with acc_out = z.
- Reset:
  - `rst` has priority over every other event.
  - state = ACCUM, acc = 0, count = 0, overflow = 0, out_valid = 0.
  - `in_ready` = 0 while `rst` is high, and 1 on the first cycle after release.
  - A partial sum, or an unconsumed result, is discarded when reset is asserted.

## Timing

- Throughput:
  - One product per cycle while in ACCUM.
  - With out_ready tied high: N_TERMS+1 cycles per result, since each result costs one cycle in DONE.
- Latency: out_valid rises on the clock edge that accepts the last term, i.e. it is visible the cycle after that term is presented.
- Result handshake: the edge where out_valid && out_ready is high leaves DONE. in_ready is 1 in the next cycle; there is no same-cycle bypass from output to input.
- All outputs are registered or decoded from state only. There are no combinational paths from in_valid, z, or out_ready to any output.
- Inputs are sampled only on rising clk edges. The z value is don't-care when in_valid = 0.

## Test plan

- Basic dot product, N_TERMS = 4, ACC_W = 24:
  - Stimulus: z = 420, 4410, 3864, 8 on consecutive cycles, out_ready = 1.
  - Required: out_valid for exactly one cycle, acc_out = 8702, overflow = 0; in_ready = 0 for that cycle.
- Bubbles and backpressure:
  - Stimulus: same four products with in_valid deasserted between terms, out_ready = 0 for 5 cycles after completion.
  - Required: acc_out holds 8702 and in_ready holds 0 for all 5 cycles; after out_ready rises, the next four terms 1, 2, 3, 4 give acc_out = 10 (accumulator was cleared).
- Overflow, N_TERMS = 4, ACC_W = 17:
  - Stimulus: z = 65025 four times.
  - Required: acc_out = 129028, overflow = 1; the next result of four 1s gives acc_out = 4 and overflow = 0.
- No overflow at the boundary, ACC_W = 18:
  - Stimulus: four 65025 terms.
  - Required: acc_out = 260100, overflow = 0.
- Reset mid-operation:
  - Stimulus: accept 420 and 4410, assert rst for 1 cycle, then send 1, 2, 3, 4.
  - Required: in_ready = 0 during rst, result = 10, no stale partial sum.
  - Repeat with rst asserted while in DONE: out_valid drops the next cycle and acc_out = 0.
- Single term, N_TERMS = 1:
  - Stimulus: z = 4410 with out_ready = 1.
  - Required: out_valid the next cycle with acc_out = 4410, alternating with in_ready = 1 cycles.
